glyph_plotter: RTL

//  Parametrised successor to the lampboard/wheel drawing loop: sequences NUM_CELLS glyph cells
//  (lamps, rotor windows, status letters) pixel-by-pixel into the 160x120 vga_adapter.

---
 rtl/enigma_pkg.sv | 31 +++
 rtl/glyph_rom.sv | 43 ++++
 rtl/glyph_plotter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared letter codes, font geometry and colours for the
// enigma display blocks.
package enigma_pkg;

  typedef enum logic [4:0] {
    LETTER_A, LETTER_B, LETTER_C, LETTER_D,
    LETTER_E, LETTER_F, LETTER_G, LETTER_H,
    LETTER_I, LETTER_J, LETTER_K, LETTER_L,
    LETTER_M, LETTER_N, LETTER_O, LETTER_P,
    LETTER_Q, LETTER_R, LETTER_S, LETTER_T,
    LETTER_U, LETTER_V, LETTER_W, LETTER_X,
    LETTER_Y, LETTER_Z, LETTER_BLANK
  } letter_e;

  localparam int FONT_W    = 5;
  localparam int FONT_H    = 5;
  localparam int FONT_BITS = FONT_W * FONT_H;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam logic [2:0] COL_YELLOW = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_NEXT,
    S_DONE
  } plot_state_e;

endpackage

// File: rtl/glyph_rom.sv
// 5x5 letter font, binary code in, bitmap out.
// Bit 24 is the top-left pixel; codes past Z are blank.
module glyph_rom
  import enigma_pkg::*;
(
  input  logic [4:0]           code,
  output logic [FONT_BITS-1:0] bitmap
);

  always_comb begin
    bitmap = '0;
    unique case (code)
      LETTER_A: bitmap = 25'b01110_10001_11111_10001_10001;
      LETTER_B: bitmap = 25'b11110_10001_11110_10001_11110;
      LETTER_C: bitmap = 25'b01111_10000_10000_10000_01111;
      LETTER_D: bitmap = 25'b11110_10001_10001_10001_11110;
      LETTER_E: bitmap = 25'b11111_10000_11110_10000_11111;
      LETTER_F: bitmap = 25'b11111_10000_11110_10000_10000;
      LETTER_G: bitmap = 25'b01111_10000_10011_10001_01111;
      LETTER_H: bitmap = 25'b10001_10001_11111_10001_10001;
      LETTER_I: bitmap = 25'b11111_00100_00100_00100_11111;
      LETTER_J: bitmap = 25'b00111_00010_00010_10010_01100;
      LETTER_K: bitmap = 25'b10001_10010_11100_10010_10001;
      LETTER_L: bitmap = 25'b10000_10000_10000_10000_11111;
      LETTER_M: bitmap = 25'b10001_11011_10101_10001_10001;
      LETTER_N: bitmap = 25'b10001_11001_10101_10011_10001;
      LETTER_O: bitmap = 25'b01110_10001_10001_10001_01110;
      LETTER_P: bitmap = 25'b11110_10001_11110_10000_10000;
      LETTER_Q: bitmap = 25'b01110_10001_10101_10010_01101;
      LETTER_R: bitmap = 25'b11110_10001_11110_10010_10001;
      LETTER_S: bitmap = 25'b01111_10000_01110_00001_11110;
      LETTER_T: bitmap = 25'b11111_00100_00100_00100_00100;
      LETTER_U: bitmap = 25'b10001_10001_10001_10001_01110;
      LETTER_V: bitmap = 25'b10001_10001_10001_01010_00100;
      LETTER_W: bitmap = 25'b10001_10001_10101_11011_10001;
      LETTER_X: bitmap = 25'b10001_01010_00100_01010_10001;
      LETTER_Y: bitmap = 25'b10001_01010_00100_00100_00100;
      LETTER_Z: bitmap = 25'b11111_00010_00100_01000_11111;
      default:  bitmap = '0;
    endcase
  end

endmodule

// File: rtl/glyph_plotter.sv
// Draws NUM_CELLS glyph cells pixel-by-pixel into the
// 160x120 vga_adapter with a start/busy/done handshake.
module glyph_plotter
  import enigma_pkg::*;
#(
  parameter int         NUM_CELLS = 4,
  parameter int         GLYPH_W   = 5,
  parameter int         GLYPH_H   = 5,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter bit         AUTO      = 1'b0,
  parameter int         SCR_W     = 160,
  parameter int         SCR_H     = 120
)(
  input  logic                   CLOCK_50,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [5*NUM_CELLS-1:0] cell_code,
  input  logic [8*NUM_CELLS-1:0] cell_x,
  input  logic [7*NUM_CELLS-1:0] cell_y,
  input  logic [3*NUM_CELLS-1:0] cell_fg,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot
);

  localparam logic [3:0] LAST_CELL = 4'(NUM_CELLS - 1);
  localparam logic [2:0] LAST_COL  = 3'(GLYPH_W - 1);
  localparam logic [2:0] LAST_ROW  = 3'(GLYPH_H - 1);

  plot_state_e state_q, state_d;
  logic [3:0]  cell_q, cell_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [4:0]  code_q, code_d;
  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [2:0]  fg_q, fg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        plot_q, plot_d;
  logic [7:0]  vx_q, vx_d;
  logic [6:0]  vy_q, vy_d;
  logic [2:0]  vc_q, vc_d;

  logic [FONT_BITS-1:0] bitmap;
  logic [7:0]           px;
  logic [6:0]           py;
  logic [4:0]           bit_idx;
  logic                 in_font;
  logic                 glyph_bit;
  logic                 on_scr;

  glyph_rom u_rom (
    .code   (code_q),
    .bitmap (bitmap)
  );

  // Coordinates wrap at 8/7 bits; the font sits top-left.
  assign px = x0_q + 8'(col_q);
  assign py = y0_q + 7'(row_q);
  assign in_font = (int'(row_q) < FONT_H) &&
                   (int'(col_q) < FONT_W);
  assign bit_idx = 5'(FONT_W * (FONT_H - 1 - int'(row_q))
                    + (FONT_W - 1 - int'(col_q)));
  assign glyph_bit = in_font && bitmap[bit_idx];
  assign on_scr = (int'(px) < SCR_W) && (int'(py) < SCR_H);

  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    row_d   = row_q;
    col_d   = col_q;
    code_d  = code_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    fg_d    = fg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    plot_d  = 1'b0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start || AUTO) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        code_d  = cell_code[5*cell_q +: 5];
        x0_d    = cell_x[8*cell_q +: 8];
        y0_d    = cell_y[7*cell_q +: 7];
        fg_d    = cell_fg[3*cell_q +: 3];
        row_d   = '0;
        col_d   = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        vx_d   = px;
        vy_d   = py;
        vc_d   = glyph_bit ? fg_q : BG_COLOUR;
        plot_d = on_scr;
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = S_NEXT;
          end else begin
            row_d = row_q + 3'd1;
          end
        end else begin
          col_d = col_q + 3'd1;
        end
      end
      S_NEXT: begin
        if (cell_q == LAST_CELL) begin
          cell_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cell_d  = cell_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        busy_d  = AUTO;
        state_d = AUTO ? S_LOAD : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cell_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      code_q  <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      fg_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      row_q   <= row_d;
      col_q   <= col_d;
      code_q  <= code_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      fg_q    <= fg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;

endmodule
